ghost_sprite_renderer: RTL and testbench

Parametrised multi-ghost sprite renderer for the VGA pixel path. It replaces the fixed three-ghost combinational renderer with NUM_GHOSTS channels and a registered sprite ROM. Per-frame position latching removes tearing. It adds two-frame walk animation and a frightened/blinking mode. It sits between the game-state logic and the pixel mux, and its RGB output is 2 cycles behind the scan coordinates.

---
 rtl/ghost_pkg.sv | 45 ++++
 rtl/ghost_sprite_rom.sv | 47 ++++
 rtl/ghost_sprite_renderer.sv | 186 ++++++++++++++++++
 tb/tb_ghost_sprite_renderer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// rtl/ghost_pkg.sv - shared types, constants and helpers for the ghost sprite renderer
//
// Purpose: colour type, transparent colour, frightened-sprite offsets,
// default sprite size, ROM address-width helper and the default sprite
// artwork generator used by ghost_sprite_rom.
// Ports: none (package).

package ghost_pkg;

    typedef logic [11:0] rgb12_t;

    localparam rgb12_t TRANSPARENT = 12'h000;

    // Frightened sprites sit just above the per-ghost sprites: NUM_GHOSTS + offset.
    typedef enum logic [0:0] {
        FRIGHT_BLUE_OFS  = 1'b0,
        FRIGHT_WHITE_OFS = 1'b1
    } sprite_sel_t;

    localparam int SPRITE_W_DEFAULT = 8;
    localparam int SPRITE_H_DEFAULT = 8;

    // Address layout is {sel, anim_frame, row, col}.
    function automatic int rom_addr_w(input int num_ghosts, input int sprite_w, input int sprite_h);
        return $clog2(num_ghosts + 2) + 1 + $clog2(sprite_h) + $clog2(sprite_w);
    endfunction

    // Default artwork: red nibble identifies the sprite (sel+1, never zero),
    // green is the row, blue is the column with bit 3 flipped on frame 1.
    // The bottom-right pixel of every sprite is transparent.
    function automatic rgb12_t sprite_pixel(input int unsigned sel, input int unsigned frame,
                                            input int unsigned row, input int unsigned col,
                                            input int unsigned last_row, input int unsigned last_col);
        rgb12_t c;
        if (row == last_row && col == last_col) begin
            c = TRANSPARENT;
        end else begin
            c[11:8] = 4'(sel + 1);
            c[7:4]  = 4'(row);
            c[3:0]  = 4'(col) ^ ((frame != 0) ? 4'h8 : 4'h0);
        end
        return c;
    endfunction

endpackage

// File: rtl/ghost_sprite_rom.sv
// rtl/ghost_sprite_rom.sv - synchronous-read sprite ROM, one cycle latency
//
// Purpose: holds NUM_GHOSTS+2 sprites (per-ghost, fright blue, fright white)
// times two animation frames. Contents come from ghost_pkg::sprite_pixel;
// unused sprite slots in the power-of-two address space read transparent.
// Ports:
//   clk   in   pixel clock
//   addr  in   {sel, anim_frame, row, col}
//   data  out  12-bit colour, valid one cycle after addr

module ghost_sprite_rom
    import ghost_pkg::*;
#(
    parameter int NUM_GHOSTS = 4,
    parameter int SPRITE_W   = SPRITE_W_DEFAULT,
    parameter int SPRITE_H   = SPRITE_H_DEFAULT,
    localparam int ADDR_W    = rom_addr_w(NUM_GHOSTS, SPRITE_W, SPRITE_H)
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output rgb12_t            data
);

    localparam int COL_W = $clog2(SPRITE_W);
    localparam int ROW_W = $clog2(SPRITE_H);
    localparam int SEL_W = ADDR_W - COL_W - ROW_W - 1;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             frame;
    logic [SEL_W-1:0] sel;

    assign col   = addr[COL_W-1:0];
    assign row   = addr[COL_W +: ROW_W];
    assign frame = addr[COL_W + ROW_W];
    assign sel   = addr[ADDR_W-1 -: SEL_W];

    always_ff @(posedge clk) begin
        if (int'(sel) < NUM_GHOSTS + 2) begin
            data <= sprite_pixel(int'(sel), int'(frame), int'(row), int'(col),
                                 SPRITE_H - 1, SPRITE_W - 1);
        end else begin
            data <= TRANSPARENT;
        end
    end

endmodule

// File: rtl/ghost_sprite_renderer.sv
// rtl/ghost_sprite_renderer.sv - multi-ghost sprite renderer for the VGA pixel path
//
// Purpose: per-frame shadowed ghost positions, lowest-index-wins hit test,
// walk animation and frightened blink, registered sprite ROM. RGB is two
// cycles behind sx/sy; one pixel per clock.
// Ports:
//   clk, rst              pixel clock, synchronous active-high reset
//   frame_start           one-cycle pulse at start of vertical blanking
//   sx, sy                scan coordinates
//   ghost_x, ghost_y      packed positions, ghost i at [i*W +: W]
//   ghost_en, frightened  per-ghost visible / frightened flags
//   fright_ending         frightened sprites blink
//   R, G, B, pix_valid    colour out; pix_valid=1 for a drawn, non-transparent pixel

module ghost_sprite_renderer
    import ghost_pkg::*;
#(
    parameter int NUM_GHOSTS   = 4,
    parameter int SPRITE_W     = SPRITE_W_DEFAULT,
    parameter int SPRITE_H     = SPRITE_H_DEFAULT,
    parameter int X_W          = 9,
    parameter int Y_W          = 9,
    parameter int SX_W         = 8,
    parameter int ANIM_PERIOD  = 8,
    parameter int BLINK_PERIOD = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic [SX_W-1:0]           sx,
    input  logic [Y_W-1:0]            sy,
    input  logic [NUM_GHOSTS*X_W-1:0] ghost_x,
    input  logic [NUM_GHOSTS*Y_W-1:0] ghost_y,
    input  logic [NUM_GHOSTS-1:0]     ghost_en,
    input  logic [NUM_GHOSTS-1:0]     frightened,
    input  logic                      fright_ending,
    output logic [3:0]                R,
    output logic [3:0]                G,
    output logic [3:0]                B,
    output logic                      pix_valid
);

    localparam int COL_W  = $clog2(SPRITE_W);
    localparam int ROW_W  = $clog2(SPRITE_H);
    localparam int SEL_W  = $clog2(NUM_GHOSTS + 2);
    localparam int ADDR_W = rom_addr_w(NUM_GHOSTS, SPRITE_W, SPRITE_H);
    localparam int AC_W   = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
    localparam int BC_W   = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

    logic [X_W-1:0]        sh_x [NUM_GHOSTS];
    logic [Y_W-1:0]        sh_y [NUM_GHOSTS];
    logic [NUM_GHOSTS-1:0] sh_en;
    logic [NUM_GHOSTS-1:0] sh_fr;

    logic [AC_W-1:0] anim_cnt;
    logic            anim_frame;
    logic [BC_W-1:0] blink_cnt;
    logic            blink_phase;

    logic             hit;
    logic             hit_q;
    logic [SEL_W-1:0] sel;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [ADDR_W-1:0] rom_addr;
    rgb12_t           rom_data;

    // Shadow copies change only at frame_start so a ghost never moves mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                sh_x[i] <= '0;
                sh_y[i] <= '0;
            end
            sh_en <= '0;
            sh_fr <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                sh_x[i] <= ghost_x[i*X_W +: X_W];
                sh_y[i] <= ghost_y[i*Y_W +: Y_W];
            end
            sh_en <= ghost_en;
            sh_fr <= frightened;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            anim_cnt    <= '0;
            anim_frame  <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (frame_start) begin
                if (anim_cnt == AC_W'(ANIM_PERIOD - 1)) begin
                    anim_cnt   <= '0;
                    anim_frame <= ~anim_frame;
                end else begin
                    anim_cnt <= anim_cnt + 1'b1;
                end
            end
            if (!fright_ending) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (frame_start) begin
                if (blink_cnt == BC_W'(BLINK_PERIOD - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // Bounds are compared one bit wider than the coordinates so a ghost near
    // the right/bottom edge cannot wrap back onto column/row 0. Scanning from
    // the highest index down lets the lowest hitting index overwrite last.
    logic [X_W:0] sx_ext;
    logic [Y_W:0] sy_ext;
    assign sx_ext = (X_W+1)'(sx);
    assign sy_ext = {1'b0, sy};

    always_comb begin
        hit = 1'b0;
        sel = '0;
        row = '0;
        col = '0;
        for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
            if (sh_en[i]
                && sx_ext >= {1'b0, sh_x[i]}
                && sx_ext <  {1'b0, sh_x[i]} + (X_W+1)'(SPRITE_W)
                && sy_ext >= {1'b0, sh_y[i]}
                && sy_ext <  {1'b0, sh_y[i]} + (Y_W+1)'(SPRITE_H)) begin
                hit = 1'b1;
                row = sy[ROW_W-1:0] - sh_y[i][ROW_W-1:0];
                col = sx[COL_W-1:0] - sh_x[i][COL_W-1:0];
                if (!sh_fr[i]) begin
                    sel = SEL_W'(i);
                end else if (fright_ending && blink_phase) begin
                    sel = SEL_W'(NUM_GHOSTS + int'(FRIGHT_WHITE_OFS));
                end else begin
                    sel = SEL_W'(NUM_GHOSTS + int'(FRIGHT_BLUE_OFS));
                end
            end
        end
    end

    assign rom_addr = {sel, anim_frame, row, col};

    ghost_sprite_rom #(
        .NUM_GHOSTS (NUM_GHOSTS),
        .SPRITE_W   (SPRITE_W),
        .SPRITE_H   (SPRITE_H)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    // hit_q travels alongside the ROM read; the ROM itself has no reset, so
    // clearing hit_q is what stops a stale word leaking out after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q     <= 1'b0;
            R         <= '0;
            G         <= '0;
            B         <= '0;
            pix_valid <= 1'b0;
        end else begin
            hit_q <= hit;
            if (hit_q && rom_data != TRANSPARENT) begin
                R         <= rom_data[11:8];
                G         <= rom_data[7:4];
                B         <= rom_data[3:0];
                pix_valid <= 1'b1;
            end else begin
                R         <= '0;
                G         <= '0;
                B         <= '0;
                pix_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ghost_sprite_renderer.sv
// tb/tb_ghost_sprite_renderer.sv - directed self-checking bench for ghost_sprite_renderer

module tb_ghost_sprite_renderer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic [7:0]  sx = '0;
    logic [8:0]  sy = '0;
    logic [35:0] ghost_x = '0;
    logic [35:0] ghost_y = '0;
    logic [3:0]  ghost_en = '0;
    logic [3:0]  frightened = '0;
    logic        fright_ending = 1'b0;
    logic [3:0]  R, G, B;
    logic        pix_valid;

    int vectors = 0;
    int miscompares = 0;

    ghost_sprite_renderer #(
        .NUM_GHOSTS   (4),
        .SPRITE_W     (8),
        .SPRITE_H     (8),
        .X_W          (9),
        .Y_W          (9),
        .SX_W         (8),
        .ANIM_PERIOD  (8),
        .BLINK_PERIOD (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .sx            (sx),
        .sy            (sy),
        .ghost_x       (ghost_x),
        .ghost_y       (ghost_y),
        .ghost_en      (ghost_en),
        .frightened    (frightened),
        .fright_ending (fright_ending),
        .R             (R),
        .G             (G),
        .B             (B),
        .pix_valid     (pix_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_frame;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic place(input int i, input int x, input int y);
        ghost_x[i*9 +: 9] = 9'(x);
        ghost_y[i*9 +: 9] = 9'(y);
    endtask

    // Present one coordinate and return the output two clocks later.
    task automatic pixel(input int x, input int y, output logic [12:0] got);
        sx = 8'(x);
        sy = 9'(y);
        tick();
        tick();
        got = {pix_valid, R, G, B};
    endtask

    task automatic test_reset;
        logic [12:0] got;
        do_reset();
        vectors++;
        if ({pix_valid, R, G, B} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0000", {pix_valid, R, G, B});
        end
        place(0, 10, 20);
        ghost_en = 4'b0001;
        pixel(10, 20, got);
        vectors++;
        if (got !== 13'h0) begin
            miscompares++;
            $display("FAIL no_draw_before_frame: got %h want 0000", got);
        end
    endtask

    task automatic test_basic;
        logic [12:0] got;
        pulse_frame();
        pixel(10, 20, got);
        vectors++;
        if (got !== 13'h1100) begin miscompares++; $display("FAIL basic_origin: got %h want 1100", got); end
        pixel(9, 20, got);
        vectors++;
        if (got !== 13'h0) begin miscompares++; $display("FAIL basic_left_edge: got %h want 0000", got); end
        pixel(18, 20, got);
        vectors++;
        if (got !== 13'h0) begin miscompares++; $display("FAIL basic_right_edge: got %h want 0000", got); end
        pixel(13, 22, got);
        vectors++;
        if (got !== 13'h1123) begin miscompares++; $display("FAIL basic_inner: got %h want 1123", got); end
        pixel(17, 26, got);
        vectors++;
        if (got !== 13'h1167) begin miscompares++; $display("FAIL basic_last_col: got %h want 1167", got); end
        pixel(17, 27, got);
        vectors++;
        if (got !== 13'h0) begin miscompares++; $display("FAIL basic_transparent: got %h want 0000", got); end
        pixel(10, 28, got);
        vectors++;
        if (got !== 13'h0) begin miscompares++; $display("FAIL basic_bottom_edge: got %h want 0000", got); end
    endtask

    task automatic test_priority;
        logic [12:0] got;
        place(0, 40, 40);
        place(2, 40, 40);
        ghost_en = 4'b0101;
        pulse_frame();
        pixel(42, 43, got);
        vectors++;
        if (got !== 13'h1132) begin miscompares++; $display("FAIL prio_ghost0_wins: got %h want 1132", got); end
        ghost_en = 4'b0100;
        pulse_frame();
        pixel(42, 43, got);
        vectors++;
        if (got !== 13'h1332) begin miscompares++; $display("FAIL prio_ghost2_alone: got %h want 1332", got); end
        ghost_en = 4'b0101;
        place(2, 41, 41);
        pulse_frame();
        pixel(47, 47, got);
        vectors++;
        if (got !== 13'h0) begin miscompares++; $display("FAIL prio_no_blend: got %h want 0000", got); end
        pixel(48, 47, got);
        vectors++;
        if (got !== 13'h1367) begin miscompares++; $display("FAIL prio_ghost2_exposed: got %h want 1367", got); end
    endtask

    task automatic test_shadow;
        logic [12:0] got;
        ghost_en = 4'b0001;
        place(0, 100, 50);
        pulse_frame();
        pixel(100, 50, got);
        vectors++;
        if (got !== 13'h1100) begin miscompares++; $display("FAIL shadow_initial: got %h want 1100", got); end
        place(0, 120, 50);
        pixel(100, 50, got);
        vectors++;
        if (got !== 13'h1100) begin miscompares++; $display("FAIL shadow_old_kept: got %h want 1100", got); end
        pixel(120, 50, got);
        vectors++;
        if (got !== 13'h0) begin miscompares++; $display("FAIL shadow_new_hidden: got %h want 0000", got); end
        pulse_frame();
        pixel(120, 50, got);
        vectors++;
        if (got !== 13'h1100) begin miscompares++; $display("FAIL shadow_new_drawn: got %h want 1100", got); end
        pixel(100, 50, got);
        vectors++;
        if (got !== 13'h0) begin miscompares++; $display("FAIL shadow_old_gone: got %h want 0000", got); end
    endtask

    task automatic test_anim;
        logic [12:0] got;
        do_reset();
        place(0, 10, 20);
        ghost_en = 4'b0001;
        frightened = 4'b0000;
        repeat (7) pulse_frame();
        pixel(11, 20, got);
        vectors++;
        if (got !== 13'h1101) begin miscompares++; $display("FAIL anim_frame0_after7: got %h want 1101", got); end
        pulse_frame();
        pixel(11, 20, got);
        vectors++;
        if (got !== 13'h1109) begin miscompares++; $display("FAIL anim_frame1_after8: got %h want 1109", got); end
    endtask

    task automatic test_blink;
        logic [12:0] got;
        do_reset();
        place(1, 60, 30);
        ghost_en = 4'b0010;
        frightened = 4'b0010;
        fright_ending = 1'b1;
        repeat (15) pulse_frame();
        pixel(60, 30, got);
        vectors++;
        if (got !== 13'h1508) begin miscompares++; $display("FAIL blink_blue_frame15: got %h want 1508", got); end
        pulse_frame();
        pixel(60, 30, got);
        vectors++;
        if (got !== 13'h1600) begin miscompares++; $display("FAIL blink_white_frame16: got %h want 1600", got); end
        fright_ending = 1'b0;
        pixel(60, 30, got);
        vectors++;
        if (got !== 13'h1500) begin miscompares++; $display("FAIL blink_drop_blue: got %h want 1500", got); end
        fright_ending = 1'b1;
        pixel(60, 30, got);
        vectors++;
        if (got !== 13'h1500) begin miscompares++; $display("FAIL blink_phase_cleared: got %h want 1500", got); end
        fright_ending = 1'b0;
        frightened = 4'b0000;
    endtask

    task automatic test_no_wrap;
        logic [12:0] got;
        int hits;
        do_reset();
        place(0, 508, 0);
        ghost_en = 4'b0001;
        pulse_frame();
        hits = 0;
        sy = 9'd3;
        for (int k = 0; k <= 256; k++) begin
            if (k < 256) sx = 8'(k);
            tick();
            if (k >= 1 && pix_valid) hits++;
        end
        vectors++;
        if (hits !== 0) begin miscompares++; $display("FAIL nowrap_sweep: got %0d drawn pixels want 0", hits); end
        place(1, 248, 0);
        ghost_en = 4'b0011;
        pulse_frame();
        pixel(255, 3, got);
        vectors++;
        if (got !== 13'h1237) begin miscompares++; $display("FAIL nowrap_right_edge: got %h want 1237", got); end
        pixel(0, 3, got);
        vectors++;
        if (got !== 13'h0) begin miscompares++; $display("FAIL nowrap_col0: got %h want 0000", got); end
    endtask

    task automatic test_back_to_back;
        logic [12:0] exp_tbl [12];
        exp_tbl = '{13'h0, 13'h0, 13'h1110, 13'h1111, 13'h1112, 13'h1113,
                    13'h1114, 13'h1115, 13'h1116, 13'h1117, 13'h0, 13'h0};
        do_reset();
        place(0, 10, 20);
        ghost_en = 4'b0001;
        pulse_frame();
        sy = 9'd21;
        for (int k = 0; k <= 12; k++) begin
            if (k < 12) sx = 8'(8 + k);
            tick();
            if (k >= 1) begin
                vectors++;
                if ({pix_valid, R, G, B} !== exp_tbl[k-1]) begin
                    miscompares++;
                    $display("FAIL b2b_sx%0d: got %h want %h", 7 + k, {pix_valid, R, G, B}, exp_tbl[k-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        sx = 8'd12;
        sy = 9'd20;
        tick();
        tick();
        vectors++;
        if ({pix_valid, R, G, B} !== 13'h1102) begin
            miscompares++;
            $display("FAIL rstmid_before: got %h want 1102", {pix_valid, R, G, B});
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({pix_valid, R, G, B} !== 13'h0) begin
            miscompares++;
            $display("FAIL rstmid_cleared: got %h want 0000", {pix_valid, R, G, B});
        end
        rst = 1'b0;
        tick();
        vectors++;
        if ({pix_valid, R, G, B} !== 13'h0) begin
            miscompares++;
            $display("FAIL rstmid_no_stale: got %h want 0000", {pix_valid, R, G, B});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_shadow();
        test_anim();
        test_blink();
        test_no_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
